// File: rtl/riscv_pkg.sv
// Shared front-end types: fetch entry layout, fetch FSM states and PC helpers.
// Pure declarations; no timing or flow-control behaviour.
package riscv_pkg;

   localparam int          XLEN    = 32;
   localparam int          INST_W  = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, registered storage; head visible the cycle after push (no bypass).
// Push is dropped when full unless a pop happens in the same cycle; flush beats push and pop.
module sync_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  T              push_dat_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output T              head_dat_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o
);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CW'(DEPTH));
   assign count_o    = count_q;
   assign head_dat_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: sequential word requests, prefetch FIFO of {pc,inst}, redirect flush.
// Request-to-inst_valid latency >= 2 cycles; issue is credit-limited so FIFO never overflows.
module inst_fetch_unit
   import riscv_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] discard_q, discard_d;

   fetch_entry_t  fifo_head, fifo_push_dat;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty, fifo_full;
   logic          fifo_push, fifo_pop;

   logic          run, redirect_act, req_acc, rsp_ok;
   logic [CW:0]   credits_used;

   assign run          = (state_q == RUN);
   assign redirect_act = run && redirect;
   // Every accepted request reserves a FIFO slot until its response is pushed or dropped.
   assign credits_used = {1'b0, fifo_count} + {1'b0, outst_q};

   assign imem_req_valid = run && !redirect && (credits_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_acc        = imem_req_valid && imem_req_ready;
   assign rsp_ok         = imem_rsp_valid && (outst_q != '0);

   assign inst_valid = !fifo_empty;
   assign inst       = fifo_head.inst;
   assign inst_pc    = fifo_head.pc;
   assign fifo_pop   = inst_valid && inst_ready && !redirect_act;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outst_d       = outst_q + CW'(req_acc) - CW'(rsp_ok);
      discard_d     = discard_q;
      fifo_push     = 1'b0;
      fifo_push_dat = '{pc: rsp_pc_q, inst: imem_rsp_data};

      case (state_q)
         BOOT:    state_d = RUN;
         default: state_d = RUN;
      endcase

      if (redirect_act) begin
         // Everything still in flight, minus a response landing now, is stale.
         fetch_pc_d = word_align(redirect_pc);
         rsp_pc_d   = word_align(redirect_pc);
         discard_d  = outst_d;
      end else begin
         if (req_acc) fetch_pc_d = fetch_pc_q + PC_STEP;
         if (rsp_ok) begin
            if (discard_q != '0) begin
               discard_d = discard_q - 1'b1;
            end else begin
               fifo_push = !fifo_full || fifo_pop;
               rsp_pc_d  = rsp_pc_q + PC_STEP;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
      end
   end

   sync_fifo #(
      .T     (fetch_entry_t),
      .DEPTH (DEPTH)
   ) u_prefetch_fifo (
      .clk_i      (clk),
      .rst_ni     (rst),
      .push_i     (fifo_push),
      .push_dat_i (fifo_push_dat),
      .pop_i      (fifo_pop),
      .flush_i    (redirect_act),
      .head_dat_o (fifo_head),
      .count_o    (fifo_count),
      .empty_o    (fifo_empty),
      .full_o     (fifo_full)
   );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: in-order memory model returning ~addr per word,
// hand-computed request/pop sequences for boot, backpressure, stalls, redirects, wrap, reset.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid, imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = '0;
   logic        inst_valid, inst_ready = 1'b1;
   logic [31:0] inst, inst_pc;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;

   inst_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] acc_addr[$];
   int          acc_edge[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_inst[$];
   int          pop_edge[$];

   int cyc   = 0;
   int lat   = 1;
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] acc_addr_at(input int i);
      return (i < acc_addr.size()) ? acc_addr[i] : 32'hBAD0_BAD0;
   endfunction
   function automatic logic [31:0] acc_edge_at(input int i);
      return (i < acc_edge.size()) ? 32'(acc_edge[i]) : 32'hBAD0_BAD0;
   endfunction
   function automatic logic [31:0] pop_pc_at(input int i);
      return (i < pop_pc.size()) ? pop_pc[i] : 32'hBAD0_BAD0;
   endfunction
   function automatic logic [31:0] pop_inst_at(input int i);
      return (i < pop_inst.size()) ? pop_inst[i] : 32'hBAD0_BAD0;
   endfunction
   function automatic logic [31:0] pop_edge_at(input int i);
      return (i < pop_edge.size()) ? 32'(pop_edge[i]) : 32'hBAD0_BAD0;
   endfunction

   // Called mid-cycle: drives memory for the coming edge, logs the handshakes that edge takes.
   task automatic tick();
      mreq_t r;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (rst && mq.size() > 0 && mq[0].due <= cyc + 1) begin
         r              = mq.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = ~r.addr;
      end
      #1;
      if (rst && imem_req_valid && imem_req_ready) begin
         mq.push_back('{addr: imem_req_addr, due: cyc + 1 + lat});
         acc_addr.push_back(imem_req_addr);
         acc_edge.push_back(cyc + 1);
      end
      if (rst && inst_valid && inst_ready && !redirect) begin
         pop_pc.push_back(inst_pc);
         pop_inst.push_back(inst);
         pop_edge.push_back(cyc + 1);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rst_req_vld"},  {31'b0, imem_req_valid}, 32'h0);
      chk({tag, "_rst_req_addr"}, imem_req_addr,           32'h0);
      chk({tag, "_rst_inst_vld"}, {31'b0, inst_valid},     32'h0);
      chk({tag, "_rst_inst"},     inst,                    32'h0);
      chk({tag, "_rst_inst_pc"},  inst_pc,                 32'h0);
   endtask

   task automatic do_reset(input string tag);
      rst            = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      mq.delete();
      acc_addr.delete();
      acc_edge.delete();
      pop_pc.delete();
      pop_inst.delete();
      pop_edge.delete();
      #1;
      check_reset_outputs(tag);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk({tag, "_boot_no_req"}, {31'b0, imem_req_valid}, 32'h0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clk);
      #1;

      // 1: streaming at one instruction per cycle
      lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      do_reset("t1");
      chk("t1_first_req_vld",  {31'b0, imem_req_valid}, 32'h1);
      chk("t1_first_req_addr", imem_req_addr, 32'h0);
      repeat (8) tick();
      for (int i = 0; i < 4; i++) begin
         chk("t1_pc",   pop_pc_at(i),   32'(i * 4));
         chk("t1_inst", pop_inst_at(i), ~32'(i * 4));
      end
      chk("t1_rate",    pop_edge_at(3) - pop_edge_at(0), 32'd3);
      chk("t1_latency", pop_edge_at(0) - acc_edge_at(0), 32'd2);

      // 2: decode stalled, credits exhaust after DEPTH requests
      inst_ready = 1'b0;
      do_reset("t2");
      repeat (10) tick();
      chk("t2_acc_count", 32'(acc_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("t2_acc_addr", acc_addr_at(i), 32'(i * 4));
      chk("t2_req_blocked", {31'b0, imem_req_valid}, 32'h0);
      chk("t2_head_vld",    {31'b0, inst_valid},     32'h1);
      chk("t2_head_pc",     inst_pc,                 32'h0);
      inst_ready = 1'b1;
      repeat (4) tick();
      chk("t2_fifth_addr", acc_addr_at(4), 32'h10);
      chk("t2_fifth_after_pop", acc_edge_at(4), pop_edge_at(0) + 32'd1);

      // 3: memory not ready, request held stable
      imem_req_ready = 1'b0; inst_ready = 1'b1;
      do_reset("t3");
      repeat (3) begin
         chk("t3_hold_vld",  {31'b0, imem_req_valid}, 32'h1);
         chk("t3_hold_addr", imem_req_addr, 32'h0);
         tick();
      end
      chk("t3_no_acc", 32'(acc_addr.size()), 32'd0);
      imem_req_ready = 1'b1;
      repeat (3) tick();
      chk("t3_acc0", acc_addr_at(0), 32'h0);
      chk("t3_acc1", acc_addr_at(1), 32'h4);

      // 4: redirect with two requests in flight
      lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
      do_reset("t4");
      tick();
      tick();
      redirect = 1'b1; redirect_pc = 32'h103;
      #1;
      chk("t4_redir_gates_req", {31'b0, imem_req_valid}, 32'h0);
      tick();
      redirect = 1'b0;
      #1;
      chk("t4_new_vld",  {31'b0, imem_req_valid}, 32'h1);
      chk("t4_new_addr", imem_req_addr, 32'h100);
      repeat (10) tick();
      chk("t4_acc_after", acc_addr_at(2), 32'h100);
      for (int i = 0; i < 3; i++) begin
         chk("t4_pc",   pop_pc_at(i),   32'h100 + 32'(i * 4));
         chk("t4_inst", pop_inst_at(i), ~(32'h100 + 32'(i * 4)));
      end

      // 5: redirect coinciding with a response, one more request still in flight
      lat = 2; imem_req_ready = 1'b1; inst_ready = 1'b0;
      do_reset("t5");
      repeat (3) tick();
      redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      #1;
      chk("t5_flushed",  {31'b0, inst_valid}, 32'h0);
      chk("t5_new_addr", imem_req_addr, 32'h200);
      inst_ready = 1'b1;
      repeat (10) tick();
      chk("t5_acc_after", acc_addr_at(3), 32'h200);
      for (int i = 0; i < 3; i++) begin
         chk("t5_pc",   pop_pc_at(i),   32'h200 + 32'(i * 4));
         chk("t5_inst", pop_inst_at(i), ~(32'h200 + 32'(i * 4)));
      end

      // 6: address wrap, then asynchronous reset mid-burst
      lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      do_reset("t6");
      tick();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      repeat (6) tick();
      chk("t6_pc0",   pop_pc_at(0),   32'hFFFF_FFFC);
      chk("t6_inst0", pop_inst_at(0), 32'h0000_0003);
      chk("t6_pc1",   pop_pc_at(1),   32'h0000_0000);
      chk("t6_inst1", pop_inst_at(1), 32'hFFFF_FFFF);
      chk("t6_busy_before_rst", {31'b0, inst_valid}, 32'h1);
      rst = 1'b0;
      #1;
      check_reset_outputs("t6_async");
      do_reset("t6b");
      repeat (4) tick();
      chk("t6_restart_addr", acc_addr_at(0), 32'h0);
      chk("t6_restart_pc",   pop_pc_at(0),   32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
